// File: rtl/sram_access_arbiter.sv
// Arbitrates the single ZBT SRAM port between the packet-store writer and the
// packet-remove reader: capped bursts, one turnaround cycle per direction change.
module sram_access_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH/8,
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_RD_LATENCY = 3,
  parameter int MAX_BURST       = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                wr_0_req,
  input  logic [SRAM_ADDR_WIDTH-1:0]          wr_0_addr,
  input  logic [DATA_WIDTH+CTRL_WIDTH-1:0]    wr_0_data,
  output logic                                wr_0_ack,
  input  logic                                rd_0_req,
  input  logic [SRAM_ADDR_WIDTH-1:0]          rd_0_addr,
  output logic                                rd_0_ack,
  output logic                                rd_0_vld,
  output logic [DATA_WIDTH+CTRL_WIDTH-1:0]    rd_0_data,
  output logic [SRAM_ADDR_WIDTH-1:0]          sram_addr,
  output logic                                sram_we,
  output logic [DATA_WIDTH+CTRL_WIDTH-1:0]    sram_wr_data,
  output logic                                sram_tri_en,
  input  logic [DATA_WIDTH+CTRL_WIDTH-1:0]    sram_rd_data
);

  localparam logic [7:0] CAP = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {OWN_WR, OWN_RD, TURN} state_t;

  state_t                     state;
  logic                       next_owner;   // 1: reader owns after TURN
  logic [7:0]                 burst_cnt;
  logic [SRAM_RD_LATENCY-1:0] vld_pipe;
  logic                       own_req, oth_req;

  // Acks are gated by reset so nothing is consumed while the block is held in reset.
  assign wr_0_ack = reset_n && (state == OWN_WR) && wr_0_req;
  assign rd_0_ack = reset_n && (state == OWN_RD) && rd_0_req;

  assign own_req = (state == OWN_WR) ? wr_0_req : rd_0_req;
  assign oth_req = (state == OWN_WR) ? rd_0_req : wr_0_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= OWN_WR;
      next_owner <= 1'b0;
      burst_cnt  <= '0;
    end else begin
      case (state)
        TURN: state <= next_owner ? OWN_RD : OWN_WR;
        OWN_WR, OWN_RD: begin
          if (oth_req && (!own_req || burst_cnt == CAP)) begin
            state      <= TURN;
            next_owner <= (state == OWN_WR);
            burst_cnt  <= '0;
          end else if (own_req) begin
            if (burst_cnt != CAP) burst_cnt <= burst_cnt + 8'd1;
          end else begin
            burst_cnt <= '0;
          end
        end
        default: state <= OWN_WR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_addr    <= '0;
      sram_we      <= 1'b0;
      sram_wr_data <= '0;
      sram_tri_en  <= 1'b0;
    end else if (wr_0_ack) begin
      sram_addr    <= wr_0_addr;
      sram_wr_data <= wr_0_data;
      sram_we      <= 1'b1;
      sram_tri_en  <= 1'b1;
    end else begin
      if (rd_0_ack) sram_addr <= rd_0_addr;
      sram_we     <= 1'b0;
      sram_tri_en <= 1'b0;
    end
  end

  // Read return: ack marker travels the pipe, data is captured as it leaves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      rd_0_vld  <= 1'b0;
      rd_0_data <= '0;
    end else begin
      vld_pipe[0] <= rd_0_ack;
      for (int i = 1; i < SRAM_RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      rd_0_vld <= vld_pipe[SRAM_RD_LATENCY-1];
      if (vld_pipe[SRAM_RD_LATENCY-1]) rd_0_data <= sram_rd_data;
    end
  end

endmodule
